// File: rtl/ysyx_22040895_mem_arb.sv
// ysyx_22040895_mem_arb: round-robin IF/LSU arbiter onto one data-memory port.
// One transaction in flight; lane masks, store alignment, load extraction and misalignment errors.
module ysyx_22040895_mem_arb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_rdy_o,
    output logic                if_rvalid_o,
    output logic [31:0]         if_rdata_o,
    output logic                if_err_o,
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [1:0]          ls_size_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    output logic                ls_rdy_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,
    output logic                ls_err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;
    state_t state, state_nx;
    // last_ls doubles as the owner of the transaction in flight
    logic last_ls, pick_ls, accept, misalign, done;
    logic [ADDR_W-1:0] a_addr;
    logic [1:0] a_size, size_q;
    logic [2:0] off_q, amask;
    logic [7:0] lane;
    logic [DATA_W-1:0] shifted, lmask;

    assign pick_ls = ls_req_i && (!if_req_i || !last_ls);
    assign accept = rst && state == IDLE && (if_req_i || ls_req_i);
    assign ls_rdy_o = accept && pick_ls;
    assign if_rdy_o = accept && !pick_ls;
    assign a_addr = pick_ls ? ls_addr_i : if_addr_i;
    assign a_size = pick_ls ? ls_size_i : 2'd2;
    assign amask = (3'd1 << a_size) - 3'd1;
    assign misalign = |(a_addr[2:0] & amask);
    assign lane = a_size == 2'd0 ? 8'h01 : a_size == 2'd1 ? 8'h03 : a_size == 2'd2 ? 8'h0F : 8'hFF;
    assign mem_req_o = state == REQ;
    assign done = state == ERR || (state == WAIT && mem_rvalid_i);
    assign shifted = mem_rdata_i >> {off_q, 3'b000};
    assign lmask = size_q == 2'd0 ? 64'hFF : size_q == 2'd1 ? 64'hFFFF :
                   size_q == 2'd2 ? 64'hFFFF_FFFF : '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = misalign ? ERR : REQ;
            REQ:  if (mem_gnt_i) state_nx = WAIT;
            WAIT: if (mem_rvalid_i) state_nx = IDLE;
            ERR:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_ls     <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wmask_o <= '0;
            off_q       <= '0;
            size_q      <= '0;
            if_rvalid_o <= 1'b0;
            if_err_o    <= 1'b0;
            if_rdata_o  <= '0;
            ls_rvalid_o <= 1'b0;
            ls_err_o    <= 1'b0;
            ls_rdata_o  <= '0;
        end else begin
            if_rvalid_o <= 1'b0;
            if_err_o    <= 1'b0;
            ls_rvalid_o <= 1'b0;
            ls_err_o    <= 1'b0;
            if (accept) begin
                last_ls     <= pick_ls;
                mem_we_o    <= pick_ls && ls_we_i;
                mem_addr_o  <= {a_addr[ADDR_W-1:3], 3'b000};
                mem_wdata_o <= ls_wdata_i << {a_addr[2:0], 3'b000};
                mem_wmask_o <= (pick_ls && ls_we_i) ? lane << a_addr[2:0] : 8'h00;
                off_q       <= a_addr[2:0];
                size_q      <= a_size;
            end
            if (done && last_ls) begin
                ls_rvalid_o <= 1'b1;
                ls_err_o    <= state == ERR;
                ls_rdata_o  <= state == ERR ? '0 : shifted & lmask;
            end
            if (done && !last_ls) begin
                if_rvalid_o <= 1'b1;
                if_err_o    <= state == ERR;
                if_rdata_o  <= state == ERR ? 32'h0 : shifted[31:0];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22040895_mem_arb.sv
// tb_ysyx_22040895_mem_arb: directed checks of arbitration, lanes, load extraction, errors and reset.
module tb_ysyx_22040895_mem_arb;
    logic clk = 1'b0;
    logic rst;
    logic if_req_i, if_rdy_o, if_rvalid_o, if_err_o;
    logic [63:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic ls_req_i, ls_we_i, ls_rdy_o, ls_rvalid_o, ls_err_o;
    logic [1:0] ls_size_i;
    logic [63:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
    logic mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [7:0] mem_wmask_o;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_22040895_mem_arb dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdy_o(if_rdy_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_size_i(ls_size_i),
        .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_rdy_o(ls_rdy_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // memory side: grant immediately, return rd next cycle; ends in the completion-pulse cycle
    task automatic serve(input logic [63:0] rd);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = rd;
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    task automatic ls_set(input logic we, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d);
        ls_req_i = 1'b1; ls_we_i = we; ls_size_i = sz; ls_addr_i = a; ls_wdata_i = d;
    endtask

    initial begin
        rst = 1'b0;
        if_req_i = 1'b1; if_addr_i = 64'h0;
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_size_i = 2'd0; ls_addr_i = 64'h0; ls_wdata_i = 64'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'h0;
        #2;
        chk("rst_if_rdy", {63'h0, if_rdy_o}, 64'h0);
        chk("rst_ls_rdy", {63'h0, ls_rdy_o}, 64'h0);
        chk("rst_mem_req", {63'h0, mem_req_o}, 64'h0);
        chk("rst_mem_addr", mem_addr_o, 64'h0);
        chk("rst_rvalid", {62'h0, if_rvalid_o, ls_rvalid_o}, 64'h0);
        tick();
        if_req_i = 1'b0; ls_req_i = 1'b0;
        rst = 1'b1;
        tick();

        // IF fetch at upper word
        if_req_i = 1'b1; if_addr_i = 64'h8000_0004;
        #1;
        chk("if1_rdy", {62'h0, if_rdy_o, ls_rdy_o}, 64'h2);
        tick();
        if_req_i = 1'b0;
        chk("if1_req", {63'h0, mem_req_o}, 64'h1);
        chk("if1_addr", mem_addr_o, 64'h8000_0000);
        chk("if1_mask_we", {55'h0, mem_we_o, mem_wmask_o}, 64'h0);
        serve(64'h1111_2222_3333_4444);
        chk("if1_rvalid", {62'h0, if_rvalid_o, if_err_o}, 64'h2);
        chk("if1_rdata", {32'h0, if_rdata_o}, 64'h1111_2222);
        tick();
        chk("if1_pulse_end", {63'h0, if_rvalid_o}, 64'h0);
        chk("if1_rdata_hold", {32'h0, if_rdata_o}, 64'h1111_2222);

        // tie: LSU first, then IF
        if_req_i = 1'b1; if_addr_i = 64'h20;
        ls_set(1'b0, 2'd3, 64'h10, 64'h0);
        #1;
        chk("tie1_rdy", {62'h0, if_rdy_o, ls_rdy_o}, 64'h1);
        tick();
        ls_req_i = 1'b0;
        chk("tie1_addr", mem_addr_o, 64'h10);
        serve(64'h0123_4567_89AB_CDEF);
        chk("tie1_ls_rdata", ls_rdata_o, 64'h0123_4567_89AB_CDEF);
        chk("tie1_ls_rvalid", {62'h0, ls_rvalid_o, ls_err_o}, 64'h2);
        chk("tie2_if_rdy", {62'h0, if_rdy_o, ls_rdy_o}, 64'h2);
        tick();
        if_req_i = 1'b0;
        chk("tie2_addr", mem_addr_o, 64'h20);
        serve(64'hCAFE_BABE_DEAD_BEEF);
        chk("tie2_if_rdata", {32'h0, if_rdata_o}, 64'hDEAD_BEEF);
        if_req_i = 1'b1;
        ls_set(1'b0, 2'd3, 64'h18, 64'h0);
        #1;
        chk("tie3_rdy", {62'h0, if_rdy_o, ls_rdy_o}, 64'h1);
        if_req_i = 1'b0; ls_req_i = 1'b0;
        tick();
        chk("withdraw_no_req", {63'h0, mem_req_o}, 64'h0);

        // store byte
        ls_set(1'b1, 2'd0, 64'h1003, 64'hAB);
        tick();
        ls_req_i = 1'b0;
        chk("sb_we_mask", {55'h0, mem_we_o, mem_wmask_o}, 64'h108);
        chk("sb_wdata", mem_wdata_o, 64'hAB00_0000);
        chk("sb_addr", mem_addr_o, 64'h1000);
        serve(64'h0);
        chk("sb_done", {62'h0, ls_rvalid_o, ls_err_o}, 64'h2);

        // load half
        ls_set(1'b0, 2'd1, 64'h2006, 64'hFFFF);
        tick();
        ls_req_i = 1'b0;
        chk("lh_we_mask", {55'h0, mem_we_o, mem_wmask_o}, 64'h0);
        serve(64'hBEEF_0000_0000_0000);
        chk("lh_rdata", ls_rdata_o, 64'hBEEF);

        // misaligned word load
        ls_set(1'b0, 2'd2, 64'h3002, 64'h0);
        tick();
        ls_req_i = 1'b0;
        chk("mis_no_req", {62'h0, mem_req_o, ls_rvalid_o}, 64'h0);
        tick();
        chk("mis_pulse", {62'h0, ls_rvalid_o, ls_err_o}, 64'h3);
        chk("mis_rdata", ls_rdata_o, 64'h0);
        tick();
        chk("mis_end", {62'h0, ls_rvalid_o, ls_err_o}, 64'h0);

        // misaligned fetch
        if_req_i = 1'b1; if_addr_i = 64'h8000_0002;
        tick();
        if_req_i = 1'b0;
        tick();
        chk("if_mis", {61'h0, if_rvalid_o, if_err_o, mem_req_o}, 64'h6);

        // store word with delayed grant, then reset in WAIT
        ls_set(1'b1, 2'd2, 64'h4004, 64'h1122_3344);
        tick();
        ls_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("dly_req", {63'h0, mem_req_o}, 64'h1);
            chk("dly_addr", mem_addr_o, 64'h4000);
            chk("dly_mask", {55'h0, mem_we_o, mem_wmask_o}, 64'h1F0);
            chk("dly_wdata", mem_wdata_o, 64'h1122_3344_0000_0000);
            tick();
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk("wait_req", {63'h0, mem_req_o}, 64'h0);
        rst = 1'b0;
        #1;
        chk("arst_mem", {54'h0, mem_req_o, mem_we_o, mem_wmask_o}, 64'h0);
        chk("arst_addr", mem_addr_o, 64'h0);
        chk("arst_wdata", mem_wdata_o, 64'h0);
        chk("arst_rdata", ls_rdata_o | {32'h0, if_rdata_o}, 64'h0);
        mem_rvalid_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_quiet", {60'h0, ls_rvalid_o, if_rvalid_o, mem_req_o, ls_err_o}, 64'h0);
        end
        if_req_i = 1'b1;
        ls_set(1'b0, 2'd3, 64'h0, 64'h0);
        #1;
        chk("post_rst_tie", {62'h0, if_rdy_o, ls_rdy_o}, 64'h1);
        if_req_i = 1'b0; ls_req_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
